// File: rtl/multi_sync_edge_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_sync_edge_filter: per-bit CDC synchroniser, glitch filter, edge    |
// | strobes.                                                     Rev 1.0     |
// +--------------------------------------------------------------------------+
module multi_sync_edge_filter #(
  parameter int WIDTH      = 4,
  parameter int STAGES     = 2,
  parameter int FILTER_LEN = 0,
  parameter int EDGE_MODE  = 0
) (
  input  logic             clk_fast,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] b_pulse
);

  if (STAGES < 2) begin : g_chk_stages
    $error("multi_sync_edge_filter: STAGES must be >= 2");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_chk_mode
    $error("multi_sync_edge_filter: EDGE_MODE must be 0, 1 or 2");
  end

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             sync_w;
  logic [WIDTH-1:0]             filt_w;
  logic [WIDTH-1:0]             filt_dly_q;
  logic [WIDTH-1:0]             rise_w;
  logic [WIDTH-1:0]             fall_w;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], a};
    end
  end

  assign sync_w = sync_q[STAGES-1];

  if (FILTER_LEN == 0) begin : g_no_filter
    assign filt_w = sync_w;
  end else begin : g_filter
    localparam int              CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             filt_q;
      logic             filt_d;

      // A new level is accepted only after FILTER_LEN consecutive differing samples.
      always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync_w[i] == filt_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          filt_d = sync_w[i];
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk_fast) begin
        if (rst) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign filt_w[i] = filt_q;
    end
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      filt_dly_q <= '0;
    end else begin
      filt_dly_q <= filt_w;
    end
  end

  assign rise_w  = filt_w & ~filt_dly_q;
  assign fall_w  = ~filt_w & filt_dly_q;
  assign b       = filt_w;
  assign b_pulse = (EDGE_MODE == 0) ? rise_w :
                   (EDGE_MODE == 1) ? fall_w : (rise_w | fall_w);

endmodule
`default_nettype wire

// File: tb/tb_multi_sync_edge_filter.sv
`default_nettype none
// Scoreboard bench: two configurations share one input bus; a latency/acceptance
// model schedules expected level changes and strobes, a monitor consumes them.
module tb_multi_sync_edge_filter;
  localparam int W  = 4;
  localparam int S0 = 3, F0 = 3, M0 = 2;
  localparam int S1 = 2, F1 = 0, M1 = 1;
  localparam int L0 = S0 + F0;
  localparam int L1 = S1 + F1;

  typedef struct {
    int           cyc;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } ev_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b0, p0, b1, p1;

  ev_t          q0[$];
  ev_t          q1[$];
  logic [W-1:0] exp_b0, exp_b1;
  logic [W-1:0] cur;
  int           cyc;
  int           total;
  int           bad;

  multi_sync_edge_filter #(.WIDTH(W), .STAGES(S0), .FILTER_LEN(F0), .EDGE_MODE(M0)) u_dut0 (
    .clk_fast(clk), .rst(rst), .a(a), .b(b0), .b_pulse(p0)
  );
  multi_sync_edge_filter #(.WIDTH(W), .STAGES(S1), .FILTER_LEN(F1), .EDGE_MODE(M1)) u_dut1 (
    .clk_fast(clk), .rst(rst), .a(a), .b(b1), .b_pulse(p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pmask(input int mode, input logic [W-1:0] r, input logic [W-1:0] f);
    if (mode == 0) return r;
    if (mode == 1) return f;
    return r | f;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // A level change on a, driven now, shows on b after the instance's latency.
  task automatic drive(input logic [W-1:0] ov, input logic [W-1:0] nv, input bit ok0, input bit ok1);
    ev_t e;
    if (ov == nv) return;
    e.rise = nv & ~ov;
    e.fall = ov & ~nv;
    if (ok0) begin e.cyc = cyc + L0; q0.push_back(e); end
    if (ok1) begin e.cyc = cyc + L1; q1.push_back(e); end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    exp_b0 = '0;
    exp_b1 = '0;
    hold(n);
    rst = 1'b0;
    drive('0, cur, 1'b1, 1'b1);
    hold(L0 + 2 + int'($urandom_range(0, 3)));
  endtask

  task automatic mon0();
    logic [W-1:0] ep;
    ev_t          e;
    ep = '0;
    while (q0.size() > 0 && q0[0].cyc <= cyc) begin
      e = q0.pop_front();
      exp_b0 ^= (e.rise | e.fall);
      ep |= pmask(M0, e.rise, e.fall);
    end
    check("b_flt", b0, exp_b0);
    check("pulse_flt", p0, ep);
  endtask

  task automatic mon1();
    logic [W-1:0] ep;
    ev_t          e;
    ep = '0;
    while (q1.size() > 0 && q1[0].cyc <= cyc) begin
      e = q1.pop_front();
      exp_b1 ^= (e.rise | e.fall);
      ep |= pmask(M1, e.rise, e.fall);
    end
    check("b_raw", b1, exp_b1);
    check("pulse_raw", p1, ep);
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      mon0();
      mon1();
    end
  end

  initial begin
    logic [W-1:0] nv;
    logic [W-1:0] gm;
    int           r;
    int           h;
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    a      = 4'hF;
    cur    = 4'hF;
    exp_b0 = '0;
    exp_b1 = '0;
    hold(5);
    rst = 1'b0;
    drive('0, cur, 1'b1, 1'b1);
    hold(L0 + 3);

    for (int step = 0; step < 1500; step++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        nv = W'($urandom);
        drive(cur, nv, 1'b1, 1'b1);
        a   = nv;
        cur = nv;
        hold(int'($urandom_range(1, L0 + 1)));
        do_reset(int'($urandom_range(1, 4)));
      end else if (r < 7) begin
        gm = W'($urandom_range(1, 15));
        h  = int'($urandom_range(1, F0 + 1));
        drive(cur, cur ^ gm, h >= F0, h >= F1);
        a = cur ^ gm;
        hold(h);
        drive(cur ^ gm, cur, h >= F0, h >= F1);
        a = cur;
        hold(L0 + 2 + int'($urandom_range(0, 3)));
      end else begin
        nv = W'($urandom);
        drive(cur, nv, 1'b1, 1'b1);
        a   = nv;
        cur = nv;
        hold(L0 + 2 + int'($urandom_range(0, 3)));
      end
    end

    hold(L0 + 4);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL pending_events actual=%0d/%0d required=0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
